// File: rtl/ps2_rx_frame.sv
// PS/2 keyboard receiver: glitch-filters the keyboard clock, deserialises one
// 11-bit frame (start, 8 data LSB-first, odd parity, stop) and pulses the scan code out.
module ps2_rx_frame #(
  parameter int unsigned FILTER_LEN     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2c,
  input  logic       ps2d,
  input  logic       rx_en,
  output logic [7:0] dout,
  output logic       rx_done_tick,
  output logic       parity_err,
  output logic       frame_err,
  output logic       timeout_tick
);

  localparam int unsigned CNT_W   = $clog2(TIMEOUT_CYCLES);
  localparam int unsigned FRAME_W = 11;
  localparam int unsigned BCNT_W  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DPS  = 2'd1,
    LOAD = 2'd2
  } state_e;

  logic [FILTER_LEN-1:0] filt_q, filt_d;
  logic                  filtered_q, filtered_d;
  logic                  fall_q, fall_d;
  logic [1:0]            sync_q;
  logic                  ps2d_s;

  state_e                state_q, state_d;
  logic [BCNT_W-1:0]     n_q, n_d;
  logic [FRAME_W-1:0]    b_q, b_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [7:0]            dout_q, dout_d;
  logic                  done_q, done_d;
  logic                  perr_q, perr_d;
  logic                  ferr_q, ferr_d;
  logic                  to_q, to_d;

  assign ps2d_s = sync_q[1];

  // Clock filter: output only moves once FILTER_LEN consecutive samples agree.
  always_comb begin
    filt_d     = {ps2c, filt_q[FILTER_LEN-1:1]};
    filtered_d = filtered_q;
    if (&filt_q) begin
      filtered_d = 1'b1;
    end else if (~|filt_q) begin
      filtered_d = 1'b0;
    end
    fall_d = filtered_q & ~filtered_d;
  end

  // Completion outputs are registered on the DPS->LOAD edge so they are high while in LOAD.
  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    b_d     = b_q;
    cnt_d   = '0;
    dout_d  = dout_q;
    done_d  = 1'b0;
    perr_d  = 1'b0;
    ferr_d  = 1'b0;
    to_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (fall_q && rx_en && !ps2d_s) begin
          state_d = DPS;
          b_d     = {ps2d_s, b_q[FRAME_W-1:1]};
          n_d     = BCNT_W'(9);
        end
      end
      DPS: begin
        if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          // A coincident fall_tick is dropped with the stalled frame.
          state_d = IDLE;
          to_d    = 1'b1;
        end else if (fall_q) begin
          b_d = {ps2d_s, b_q[FRAME_W-1:1]};
          if (n_q == '0) begin
            state_d = LOAD;
            done_d  = 1'b1;
            dout_d  = b_d[8:1];
            perr_d  = ~^b_d[9:1];
            ferr_d  = ~b_d[10];
          end else begin
            n_d = n_q - BCNT_W'(1);
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      LOAD: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      filt_q     <= '1;
      filtered_q <= 1'b1;
      fall_q     <= 1'b0;
      sync_q     <= 2'b11;
      state_q    <= IDLE;
      n_q        <= '0;
      b_q        <= '0;
      cnt_q      <= '0;
      dout_q     <= '0;
      done_q     <= 1'b0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      to_q       <= 1'b0;
    end else begin
      filt_q     <= filt_d;
      filtered_q <= filtered_d;
      fall_q     <= fall_d;
      sync_q     <= {sync_q[0], ps2d};
      state_q    <= state_d;
      n_q        <= n_d;
      b_q        <= b_d;
      cnt_q      <= cnt_d;
      dout_q     <= dout_d;
      done_q     <= done_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
      to_q       <= to_d;
    end
  end

  assign dout         = dout_q;
  assign rx_done_tick = done_q;
  assign parity_err   = perr_q;
  assign frame_err    = ferr_q;
  assign timeout_tick = to_q;

endmodule

// File: tb/tb_ps2_rx_frame.sv
// Bench for ps2_rx_frame: drives PS/2 frames, scoreboards received scan codes
// and error flags, and checks glitch rejection, rx_en gating, timeout and reset.
module tb_ps2_rx_frame;

  localparam int FL   = 8;
  localparam int TO   = 50000;
  localparam int HALF = 40;

  typedef struct packed {
    logic [7:0] d;
    logic       pe;
    logic       fe;
  } frame_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       ps2c = 1'b1;
  logic       ps2d = 1'b1;
  logic       rx_en = 1'b1;
  logic [7:0] dout;
  logic       rx_done_tick;
  logic       parity_err;
  logic       frame_err;
  logic       timeout_tick;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_fall_cyc = 0;
  int to_cnt = 0;
  int to_cyc = 0;
  int overlap_cnt = 0;
  frame_t exp_q[$];
  frame_t obs_q[$];

  ps2_rx_frame #(.FILTER_LEN(FL), .TIMEOUT_CYCLES(TO)) dut (
    .clk          (clk),
    .rst          (rst),
    .ps2c         (ps2c),
    .ps2d         (ps2d),
    .rx_en        (rx_en),
    .dout         (dout),
    .rx_done_tick (rx_done_tick),
    .parity_err   (parity_err),
    .frame_err    (frame_err),
    .timeout_tick (timeout_tick)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: records what the DUT produced; comparisons happen in the test tasks.
  always @(negedge clk) begin
    if (rst) begin
      if (rx_done_tick) obs_q.push_back({dout, parity_err, frame_err});
      if (timeout_tick) begin
        to_cnt <= to_cnt + 1;
        to_cyc <= cyc;
      end
      if (rx_done_tick && timeout_tick) overlap_cnt <= overlap_cnt + 1;
    end
  end

  function automatic logic [10:0] mk_frame(input logic [7:0] d, input logic pflip,
                                           input logic stop);
    return {stop, (~^d) ^ pflip, d, 1'b0};
  endfunction

  task automatic send_bits(input logic [10:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      ps2d = bits[i];
      repeat (HALF) @(posedge clk);
      #1 ps2c = 1'b0;
      last_fall_cyc = cyc;
      repeat (HALF) @(posedge clk);
      #1 ps2c = 1'b1;
    end
    ps2d = 1'b1;
    repeat (HALF) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic pflip, input logic stop);
    if (rx_en) exp_q.push_back({d, pflip, ~stop});
    send_bits(mk_frame(d, pflip, stop), 11);
  endtask

  task automatic test_reset;
    rst = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    checks++;
    if (dout !== 8'h00) begin errors++; $display("FAIL reset_dout got %h want 00", dout); end
    checks++;
    if ({rx_done_tick, parity_err, frame_err, timeout_tick} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_ticks got %b want 0000",
               {rx_done_tick, parity_err, frame_err, timeout_tick});
    end
    #1 rst = 1'b1;
    repeat (20) @(posedge clk);
    #1;
  endtask

  task automatic test_single;
    frame_t e, o;
    send_frame(8'h1C, 1'b0, 1'b1);
    repeat (20) @(posedge clk);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin errors++; $display("FAIL single_missing want %h", e); end
      else begin
        o = obs_q.pop_front();
        if (o !== e) begin errors++; $display("FAIL single_frame got %h want %h", o, e); end
      end
    end
    checks++;
    if (obs_q.size() != 0) begin
      errors++; $display("FAIL single_extra got %0d frames want 0", obs_q.size()); obs_q.delete();
    end
    repeat (1000) @(posedge clk);
    @(negedge clk);
    checks++;
    if (dout !== 8'h1C) begin errors++; $display("FAIL single_hold got %h want 1c", dout); end
    #1;
  endtask

  task automatic test_back_to_back;
    frame_t e, o;
    send_frame(8'hF0, 1'b0, 1'b1);
    send_frame(8'h1C, 1'b0, 1'b1);
    repeat (20) @(posedge clk);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin errors++; $display("FAIL b2b_missing want %h", e); end
      else begin
        o = obs_q.pop_front();
        if (o !== e) begin errors++; $display("FAIL b2b_frame got %h want %h", o, e); end
      end
    end
    checks++;
    if (obs_q.size() != 0) begin
      errors++; $display("FAIL b2b_extra got %0d frames want 0", obs_q.size()); obs_q.delete();
    end
  endtask

  task automatic test_errors;
    frame_t e, o;
    send_frame(8'h1C, 1'b1, 1'b1);
    send_frame(8'h1C, 1'b0, 1'b0);
    send_frame(8'hA5, 1'b1, 1'b0);
    repeat (20) @(posedge clk);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin errors++; $display("FAIL err_missing want %h", e); end
      else begin
        o = obs_q.pop_front();
        if (o !== e) begin errors++; $display("FAIL err_frame got %h want %h", o, e); end
      end
    end
    checks++;
    if (obs_q.size() != 0) begin
      errors++; $display("FAIL err_extra got %0d frames want 0", obs_q.size()); obs_q.delete();
    end
  endtask

  task automatic test_glitch_and_gate;
    int to_before;
    to_before = to_cnt;
    // Low pulse shorter than the filter while data is low would look like a start bit.
    ps2d = 1'b0;
    repeat (10) @(posedge clk);
    #1 ps2c = 1'b0;
    repeat (5) @(posedge clk);
    #1 ps2c = 1'b1;
    repeat (10) @(posedge clk);
    #1 ps2d = 1'b1;
    repeat (100) @(posedge clk);
    #1 rx_en = 1'b0;
    send_frame(8'h1C, 1'b0, 1'b1);
    rx_en = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    checks++;
    if (obs_q.size() != 0) begin
      errors++; $display("FAIL gate_frames got %0d frames want 0", obs_q.size()); obs_q.delete();
    end
    checks++;
    if (to_cnt != to_before) begin
      errors++; $display("FAIL gate_timeout got %0d timeouts want 0", to_cnt - to_before);
    end
    checks++;
    if (dout !== 8'hA5) begin errors++; $display("FAIL gate_dout got %h want a5", dout); end
  endtask

  task automatic test_timeout;
    frame_t e, o;
    int to_before, budget;
    to_before = to_cnt;
    send_bits(mk_frame(8'h3C, 1'b0, 1'b1), 5);
    budget = 0;
    while (to_cnt == to_before && budget < TO + 500) begin
      @(posedge clk);
      budget++;
    end
    @(negedge clk);
    checks++;
    if (to_cnt != to_before + 1) begin
      errors++; $display("FAIL timeout_count got %0d want 1", to_cnt - to_before);
    end
    // fall_tick reaches the FSM FL+2 clocks after the ps2c fall; timeout counts from there.
    checks++;
    if (to_cyc - last_fall_cyc != FL + 2 + TO) begin
      errors++;
      $display("FAIL timeout_latency got %0d want %0d", to_cyc - last_fall_cyc, FL + 2 + TO);
    end
    checks++;
    if (dout !== 8'hA5 || obs_q.size() != 0) begin
      errors++; $display("FAIL timeout_dout got %h/%0d frames want a5/0", dout, obs_q.size());
      obs_q.delete();
    end
    send_frame(8'hF0, 1'b0, 1'b1);
    repeat (20) @(posedge clk);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin errors++; $display("FAIL timeout_next_missing want %h", e); end
      else begin
        o = obs_q.pop_front();
        if (o !== e) begin errors++; $display("FAIL timeout_next got %h want %h", o, e); end
      end
    end
    checks++;
    if (overlap_cnt != 0) begin
      errors++; $display("FAIL tick_overlap got %0d want 0", overlap_cnt);
    end
  endtask

  task automatic test_reset_midframe;
    frame_t e, o;
    send_bits(mk_frame(8'h55, 1'b0, 1'b1), 6);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (dout !== 8'h00 || {rx_done_tick, parity_err, frame_err, timeout_tick} !== 4'b0000) begin
      errors++;
      $display("FAIL midreset_outputs got %h/%b want 00/0000", dout,
               {rx_done_tick, parity_err, frame_err, timeout_tick});
    end
    #1 rst = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    send_frame(8'h1C, 1'b0, 1'b1);
    repeat (20) @(posedge clk);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin errors++; $display("FAIL midreset_missing want %h", e); end
      else begin
        o = obs_q.pop_front();
        if (o !== e) begin errors++; $display("FAIL midreset_frame got %h want %h", o, e); end
      end
    end
    checks++;
    if (obs_q.size() != 0) begin
      errors++; $display("FAIL midreset_extra got %0d frames want 0", obs_q.size()); obs_q.delete();
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_errors();
    test_glitch_and_gate();
    test_timeout();
    test_reset_midframe();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
